// File: rtl/cdb_issue_scheduler.sv
// cdb_issue_scheduler: decides each cycle which ready issue queues may
// dispatch so that no two results land on the common data bus together.
//
// Ports:
//   Clk, Resetb   clock (rising edge), asynchronous active-low reset
//   Fast_Rdy      per-queue ready for the single-cycle channels (bit0 int, bit1 lsb)
//   IssMul_Rdy    multiply queue has a ready instruction
//   IssDiv_Rdy    divide queue has a ready instruction
//   Div_ExeRdy    divide execution unit can accept a request
//   Iss_Fast      one-hot-or-zero grant to the single-cycle queues (combinational)
//   Iss_Mult      multiply grant (combinational)
//   Iss_Div       divide grant (combinational)
//   Res_Vec       registered CDB reservation vector; bit k = slot k+1 cycles ahead
//   Div_Busy      registered divider-interval lockout flag
module cdb_issue_scheduler #(
    parameter int unsigned NUM_FAST = 2,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned DIV_LAT  = 7,
    parameter int unsigned DIV_II   = 7,
    parameter int unsigned PTR_W    = (NUM_FAST > 1) ? $clog2(NUM_FAST) : 1
) (
    input  logic                Clk,
    input  logic                Resetb,
    input  logic [NUM_FAST-1:0] Fast_Rdy,
    input  logic                IssMul_Rdy,
    input  logic                IssDiv_Rdy,
    input  logic                Div_ExeRdy,
    output logic [NUM_FAST-1:0] Iss_Fast,
    output logic                Iss_Mult,
    output logic                Iss_Div,
    output logic [DIV_LAT-2:0]  Res_Vec,
    output logic                Div_Busy
);

    localparam int unsigned RES_W = DIV_LAT - 1;
    localparam int unsigned CNT_W = (DIV_II > 1) ? $clog2(DIV_II) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_nxt;
    logic [PTR_W-1:0] lo_idx;
    logic [PTR_W-1:0] hi_idx;
    logic [PTR_W-1:0] fast_idx;
    logic             lo_hit;
    logic             hi_hit;
    logic             fast_hit;
    logic [RES_W-1:0] res_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Long-latency grants; gated by reset so nothing issues while held in reset.
    // The divider owns slot t+DIV_LAT alone, so it needs no slot check.
    always_comb begin
        Iss_Div  = Resetb & IssDiv_Rdy & Div_ExeRdy & ~Div_Busy;
        Iss_Mult = Resetb & IssMul_Rdy & ~Res_Vec[MUL_LAT-1];
    end

    // Round-robin search: lowest ready channel at or above the pointer,
    // otherwise the lowest ready channel overall (the wrap-around case).
    always_comb begin
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        lo_idx = '0;
        hi_idx = '0;
        for (int i = int'(NUM_FAST) - 1; i >= 0; i--) begin
            if (Fast_Rdy[i]) begin
                lo_hit = 1'b1;
                lo_idx = PTR_W'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = PTR_W'(i);
                end
            end
        end
    end

    // Fast grant needs the t+1 slot free; the pointer advances only on a grant.
    always_comb begin
        fast_hit = Resetb & ~Res_Vec[0] & lo_hit;
        fast_idx = hi_hit ? hi_idx : lo_idx;
        Iss_Fast = '0;
        rr_nxt   = rr_ptr;
        if (fast_hit) begin
            Iss_Fast = NUM_FAST'(1) << fast_idx;
            rr_nxt   = (fast_idx == PTR_W'(NUM_FAST - 1)) ? '0 : fast_idx + PTR_W'(1);
        end
    end

    // Reservation shift plus new claims; divider interval countdown.
    always_comb begin
        res_nxt              = {1'b0, Res_Vec[RES_W-1:1]};
        res_nxt[MUL_LAT-2]   = res_nxt[MUL_LAT-2] | Iss_Mult;
        res_nxt[DIV_LAT-2]   = res_nxt[DIV_LAT-2] | Iss_Div;
        cnt_nxt              = div_cnt;
        if (Iss_Div) begin
            cnt_nxt = CNT_W'(DIV_II - 1);
        end else if (div_cnt != '0) begin
            cnt_nxt = div_cnt - CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            rr_ptr   <= '0;
            Res_Vec  <= '0;
            div_cnt  <= '0;
            Div_Busy <= 1'b0;
        end else begin
            rr_ptr   <= rr_nxt;
            Res_Vec  <= res_nxt;
            div_cnt  <= cnt_nxt;
            Div_Busy <= (cnt_nxt != '0);
        end
    end

endmodule
